// File: rtl/scene_raster_renderer_if.sv
// Scene-in / pixel-stream-out bundle between game-state logic, renderer and framebuffer writer.
// No logic or latency of its own; carries the pixel valid/ready pair and the scene snapshot sources.
// Backpressure is expressed only by pix_ready from the consumer side.
interface scene_raster_renderer_if #(
   parameter int NUM_BLOCKS = 16
);
   logic                     frame_start;
   logic [31:0]              doodleX;
   logic [31:0]              doodleY;
   logic [31:0]              minY;
   logic [NUM_BLOCKS*32-1:0] blocksX;
   logic [NUM_BLOCKS*32-1:0] blocksY;
   logic [NUM_BLOCKS-1:0]    isBlockActive;
   logic                     pix_valid;
   logic                     pix_ready;
   logic [31:0]              pix_x;
   logic [31:0]              pix_y;
   logic [23:0]              pix_color;
   logic                     busy;
   logic                     frame_done;
   logic                     collision;

   // Renderer side: consumes scene, produces the pixel stream.
   modport master (
      input  frame_start, doodleX, doodleY, minY, blocksX, blocksY, isBlockActive, pix_ready,
      output pix_valid, pix_x, pix_y, pix_color, busy, frame_done, collision
   );

   // Environment side: supplies scene, accepts pixels.
   modport slave (
      output frame_start, doodleX, doodleY, minY, blocksX, blocksY, isBlockActive, pix_ready,
      input  pix_valid, pix_x, pix_y, pix_color, busy, frame_done, collision
   );
endinterface

// File: rtl/scene_raster_renderer.sv
// Raster-order frame renderer: snapshots scene, emits one RGB888 pixel per cycle, flags doodle/block overlap.
// Latency: frame_start edge -> first pix_valid one edge later (2-stage: scan evaluate, output register).
// Backpressure: pix_valid && !pix_ready freezes output register, evaluate stage and scan counter.
module scene_raster_renderer #(
   parameter int          SCREEN_WIDTH  = 400,
   parameter int          SCREEN_HEIGHT = 700,
   parameter int          BLOCK_WIDTH   = 40,
   parameter int          BLOCK_HEIGHT  = 5,
   parameter int          NUM_BLOCKS    = 16,
   parameter int          DOODLE_WIDTH  = 20,
   parameter int          DOODLE_HEIGHT = 20,
   parameter logic [23:0] BKCOLOR       = 24'h0faf0f,
   parameter logic [23:0] BLOCK_COLOR   = 24'hff000f,
   parameter logic [23:0] DOODLE_COLOR  = 24'h00ff00
) (
   input logic                      clk,
   input logic                      reset,
   scene_raster_renderer_if.master  bus
);

   localparam logic [31:0] LAST_X = 32'(SCREEN_WIDTH - 1);
   localparam logic [31:0] LAST_Y = 32'(SCREEN_HEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Scene snapshot, y already converted to screen space (objY - minY, modulo 2^32).
   logic [31:0]              snap_dx;
   logic [31:0]              snap_dsy;
   logic [NUM_BLOCKS*32-1:0] snap_bx;
   logic [NUM_BLOCKS*32-1:0] snap_bsy;
   logic [NUM_BLOCKS-1:0]    snap_act;

   // Evaluate stage: the scan counter is the pixel under evaluation while in SCAN.
   logic [31:0] scan_x;
   logic [31:0] scan_y;
   logic        col_acc;

   logic        adv;
   logic        xfer;
   logic        scan_last;
   logic        load;
   logic        finish;
   logic        dood_hit;
   logic        blk_hit;
   logic [23:0] eval_color;
   logic [32:0] x33;
   logic [32:0] y33;

   assign adv       = !bus.pix_valid || bus.pix_ready;
   assign xfer      = bus.pix_valid && bus.pix_ready;
   assign scan_last = (scan_x == LAST_X) && (scan_y == LAST_Y);
   assign bus.busy  = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.frame_start) begin
               load      = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (adv && scan_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (xfer) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Hit tests in 33 bits so obj+size never wraps; an underflowed screen y is simply far off-screen.
   always_comb begin
      x33      = {1'b0, scan_x};
      y33      = {1'b0, scan_y};
      dood_hit = ({1'b0, snap_dx} <= x33) && (x33 < {1'b0, snap_dx} + 33'(DOODLE_WIDTH)) &&
                 ({1'b0, snap_dsy} <= y33) && (y33 < {1'b0, snap_dsy} + 33'(DOODLE_HEIGHT));
      blk_hit  = 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         if (snap_act[i] &&
             ({1'b0, snap_bx[32*i +: 32]} <= x33) &&
             (x33 < {1'b0, snap_bx[32*i +: 32]} + 33'(BLOCK_WIDTH)) &&
             ({1'b0, snap_bsy[32*i +: 32]} <= y33) &&
             (y33 < {1'b0, snap_bsy[32*i +: 32]} + 33'(BLOCK_HEIGHT)))
            blk_hit = 1'b1;
      end
      if (dood_hit)     eval_color = DOODLE_COLOR;
      else if (blk_hit) eval_color = BLOCK_COLOR;
      else              eval_color = BKCOLOR;
   end

   // Snapshot capture, scan counter, collision accumulator.
   always_ff @(posedge clk) begin
      if (reset) begin
         snap_dx  <= '0;
         snap_dsy <= '0;
         snap_bx  <= '0;
         snap_bsy <= '0;
         snap_act <= '0;
         scan_x   <= '0;
         scan_y   <= '0;
         col_acc  <= 1'b0;
      end else if (load) begin
         snap_dx  <= bus.doodleX;
         snap_dsy <= bus.doodleY - bus.minY;
         snap_bx  <= bus.blocksX;
         for (int i = 0; i < NUM_BLOCKS; i++)
            snap_bsy[32*i +: 32] <= bus.blocksY[32*i +: 32] - bus.minY;
         snap_act <= bus.isBlockActive;
         scan_x   <= '0;
         scan_y   <= '0;
         col_acc  <= 1'b0;
      end else if (state == SCAN && adv) begin
         col_acc <= col_acc | (dood_hit & blk_hit);
         if (scan_x == LAST_X) begin
            scan_x <= '0;
            scan_y <= scan_y + 32'd1;
         end else begin
            scan_x <= scan_x + 32'd1;
         end
      end
   end

   // Output register: loads a new pixel whenever it is empty or being drained this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.pix_valid <= 1'b0;
         bus.pix_x     <= '0;
         bus.pix_y     <= '0;
         bus.pix_color <= '0;
      end else if (adv) begin
         if (state == SCAN) begin
            bus.pix_valid <= 1'b1;
            bus.pix_x     <= scan_x;
            bus.pix_y     <= scan_y;
            bus.pix_color <= eval_color;
         end else begin
            bus.pix_valid <= 1'b0;
         end
      end
   end

   // End-of-frame pulse and per-frame collision result.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.frame_done <= 1'b0;
         bus.collision  <= 1'b0;
      end else begin
         bus.frame_done <= finish;
         if (finish) bus.collision <= col_acc;
      end
   end

endmodule

// File: tb/tb_scene_raster_renderer.sv
// Bench for scene_raster_renderer on an 8x4 screen, 3x1 blocks, 2 slots, 2x2 doodle.
// Stimulus pushes expected pixels/collision into queues; a negedge monitor pops and compares.
// Ready is either held high or randomised per cycle; stalled outputs must hold.
module tb_scene_raster_renderer;
   localparam int SW = 8, SH = 4, BW = 3, BH = 1, NB = 2, DW = 2, DH = 2;
   localparam logic [23:0] BKC = 24'h0faf0f, BLC = 24'hff000f, DOC = 24'h00ff00;

   typedef struct {
      int          x;
      int          y;
      logic [23:0] c;
   } px_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   scene_raster_renderer_if #(.NUM_BLOCKS(NB)) bus ();

   scene_raster_renderer #(
      .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH),
      .NUM_BLOCKS(NB), .DOODLE_WIDTH(DW), .DOODLE_HEIGHT(DH),
      .BKCOLOR(BKC), .BLOCK_COLOR(BLC), .DOODLE_COLOR(DOC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int  checks = 0;
   int  errors = 0;
   px_t exp_q[$];
   bit  exp_col[$];
   bit  mon_en = 1'b0;
   bit  rand_rdy = 1'b0;
   int  xfer_total = 0, blk_total = 0, dood_total = 0, frames_done = 0;

   logic [31:0] s_dx, s_dy, s_miny;
   logic [31:0] s_bx[NB];
   logic [31:0] s_by[NB];
   logic [NB-1:0] s_act;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Independent reference: 64-bit signed arithmetic, screen y taken modulo 2^32.
   function automatic logic [23:0] model(int x, int y);
      logic [31:0] t;
      longint ox, oy;
      bit d, b;
      t  = s_dy - s_miny;
      oy = longint'({32'b0, t});
      ox = longint'({32'b0, s_dx});
      d  = (x >= ox) && (x < ox + DW) && (y >= oy) && (y < oy + DH);
      b  = 1'b0;
      for (int i = 0; i < NB; i++) begin
         t  = s_by[i] - s_miny;
         oy = longint'({32'b0, t});
         ox = longint'({32'b0, s_bx[i]});
         if (s_act[i] && (x >= ox) && (x < ox + BW) && (y >= oy) && (y < oy + BH)) b = 1'b1;
      end
      return d ? DOC : (b ? BLC : BKC);
   endfunction

   task automatic set_scene(input logic [31:0] dx, dy, miny, bx0, by0, bx1, by1, input logic [1:0] act);
      s_dx = dx; s_dy = dy; s_miny = miny;
      s_bx[0] = bx0; s_by[0] = by0; s_bx[1] = bx1; s_by[1] = by1; s_act = act;
      bus.doodleX = dx; bus.doodleY = dy; bus.minY = miny;
      bus.blocksX = {bx1, bx0}; bus.blocksY = {by1, by0}; bus.isBlockActive = act;
   endtask

   // Ready driver: the only writer of pix_ready.
   initial begin
      bus.pix_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 bus.pix_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: scoreboard pop on every transfer, stall stability, frame_done/collision.
   bit          held = 1'b0, last_final = 1'b0;
   logic [87:0] held_v;
   always @(negedge clk) begin
      if (!mon_en) begin
         held       = 1'b0;
         last_final = 1'b0;
      end else begin
         if (bus.frame_done) begin
            chk("done_after_last_xfer", 96'(last_final), 96'd1);
            chk("done_valid_low", 96'(bus.pix_valid), 96'd0);
            chk("done_busy_low", 96'(bus.busy), 96'd0);
            if (exp_col.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame_done: got frame_done=1 expected no frame end");
            end else begin
               chk("collision", 96'(bus.collision), 96'(exp_col.pop_front()));
            end
            frames_done++;
         end
         if (held)
            chk("stall_hold", {7'd0, bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_color},
                {7'd0, 1'b1, held_v});
         held   = bus.pix_valid && !bus.pix_ready;
         held_v = {bus.pix_x, bus.pix_y, bus.pix_color};
         last_final = 1'b0;
         if (bus.pix_valid && bus.pix_ready) begin
            px_t e;
            xfer_total++;
            if (bus.pix_color == BLC) blk_total++;
            if (bus.pix_color == DOC) dood_total++;
            last_final = (bus.pix_x == SW - 1) && (bus.pix_y == SH - 1);
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_pixel: got (%0d,%0d) %h expected none",
                        bus.pix_x, bus.pix_y, bus.pix_color);
            end else begin
               e = exp_q.pop_front();
               chk("pixel", {8'd0, bus.pix_x, bus.pix_y, bus.pix_color},
                   {8'd0, 32'(e.x), 32'(e.y), e.c});
            end
         end
      end
   end

   int base_x, base_b, base_d;

   task automatic start_frame(input bit col);
      for (int y = 0; y < SH; y++)
         for (int x = 0; x < SW; x++) begin
            px_t p;
            p.x = x; p.y = y; p.c = model(x, y);
            exp_q.push_back(p);
         end
      exp_col.push_back(col);
      base_x = xfer_total; base_b = blk_total; base_d = dood_total;
      @(posedge clk); #1 bus.frame_start = 1'b1;
      @(posedge clk); #1 bus.frame_start = 1'b0;
      chk("busy_after_start", 96'(bus.busy), 96'd1);
      chk("valid_low_edge0", 96'(bus.pix_valid), 96'd0);
      @(posedge clk); #1;
      chk("valid_high_edge1", 96'(bus.pix_valid), 96'd1);
   endtask

   task automatic wait_frame(input int eb, input int ed, input bit restart_mid);
      int  f0 = frames_done;
      bit  pulsed = 1'b0;
      for (int c = 0; c < 600 && frames_done == f0; c++) begin
         @(posedge clk); #1;
         if (restart_mid && !pulsed && (xfer_total - base_x) >= 15) begin
            bus.frame_start = 1'b1;
            pulsed = 1'b1;
         end else begin
            bus.frame_start = 1'b0;
         end
      end
      bus.frame_start = 1'b0;
      chk("frame_done_seen", 96'(frames_done - f0), 96'd1);
      chk("busy_low_after_done", 96'(bus.busy), 96'd0);
      chk("pixel_count", 96'(xfer_total - base_x), 96'(SW * SH));
      chk("queue_drained", 96'(exp_q.size()), 96'd0);
      chk("block_pixels", 96'(blk_total - base_b), 96'(eb));
      chk("doodle_pixels", 96'(dood_total - base_d), 96'(ed));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.frame_start = 1'b0;
      set_scene(32'd0, 32'd100, 32'd0, 32'd0, 32'd100, 32'd0, 32'd100, 2'b00);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 96'(bus.pix_valid), 96'd0);
      chk("rst_xyc", {8'd0, bus.pix_x, bus.pix_y, bus.pix_color}, 96'd0);
      chk("rst_busy", 96'(bus.busy), 96'd0);
      chk("rst_done", 96'(bus.frame_done), 96'd0);
      chk("rst_collision", 96'(bus.collision), 96'd0);
      reset = 1'b0;
      mon_en = 1'b1;

      // Empty scene: all background.
      start_frame(1'b0); wait_frame(0, 0, 1'b0);
      // Block0 at (2,5), minY=3 -> row 2, x 2..4.
      set_scene(32'd0, 32'd100, 32'd3, 32'd2, 32'd5, 32'd0, 32'd100, 2'b01);
      start_frame(1'b0); wait_frame(3, 0, 1'b0);
      // Same block disabled.
      set_scene(32'd0, 32'd100, 32'd3, 32'd2, 32'd5, 32'd0, 32'd100, 2'b00);
      start_frame(1'b0); wait_frame(0, 0, 1'b0);
      // Doodle (6,1) over block (5,2): doodle wins at (6,2),(7,2).
      set_scene(32'd6, 32'd1, 32'd0, 32'd5, 32'd2, 32'd0, 32'd100, 2'b01);
      start_frame(1'b1); wait_frame(1, 4, 1'b0);
      // Same scene under random backpressure; inputs changed after snapshot must not matter.
      rand_rdy = 1'b1;
      start_frame(1'b1);
      bus.doodleX = 32'd0; bus.isBlockActive = 2'b00;
      wait_frame(1, 4, 1'b0);
      rand_rdy = 1'b0;
      // Camera underflow on doodle and block1, block0 at x=0xFFFFFFFE.
      set_scene(32'd3, 32'd1, 32'd2, 32'hFFFFFFFE, 32'd2, 32'd0, 32'd1, 2'b11);
      start_frame(1'b0); wait_frame(0, 0, 1'b0);

      // Reset mid-frame at pixel 10.
      set_scene(32'd6, 32'd1, 32'd0, 32'd5, 32'd2, 32'd0, 32'd100, 2'b01);
      start_frame(1'b1);
      for (int c = 0; c < 100 && (xfer_total - base_x) < 10; c++) begin
         @(posedge clk); #1;
      end
      chk("reached_pixel_10", 96'(xfer_total - base_x), 96'd10);
      mon_en = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_valid", 96'(bus.pix_valid), 96'd0);
      chk("midrst_xyc", {8'd0, bus.pix_x, bus.pix_y, bus.pix_color}, 96'd0);
      chk("midrst_busy", 96'(bus.busy), 96'd0);
      chk("midrst_done", 96'(bus.frame_done), 96'd0);
      chk("midrst_collision", 96'(bus.collision), 96'd0);
      reset = 1'b0;
      exp_q.delete();
      exp_col.delete();
      mon_en = 1'b1;
      // Fresh frame with a frame_start pulse mid-frame that must be ignored.
      start_frame(1'b1); wait_frame(1, 4, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("no_restart_idle", 96'(bus.busy), 96'd0);
      chk("no_restart_xfers", 96'(xfer_total - base_x), 96'(SW * SH));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/scene_raster_renderer.md
# scene_raster_renderer

Streams a full frame of pixel colours for the doodle-jump screen in raster order (x fastest, then y), one pixel per cycle under valid/ready flow control. It sits between the game-state logic (doodle position, block table, camera `minY`) and the display/framebuffer writer. Unlike the single-pixel combinational colour resolver, it is sequential: it snapshots the scene at frame start, scans every pixel itself, supports N block slots, a sized doodle sprite, camera offset on all objects, and reports doodle/block overlap per frame.

## Interface
- SCREEN_WIDTH, 400, pixels per row
- SCREEN_HEIGHT, 700, rows per frame
- BLOCK_WIDTH, 40, block width in pixels
- BLOCK_HEIGHT, 5, block height in pixels
- NUM_BLOCKS, 16, block slots
- DOODLE_WIDTH, 20, doodle sprite width
- DOODLE_HEIGHT, 20, doodle sprite height
- BKCOLOR / BLOCK_COLOR / DOODLE_COLOR, 24'h0faf0f / 24'hff000f / 24'h00ff00, RGB888 colours

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- frame_start  in  1  pulse; starts a frame when idle
- doodleX, doodleY, minY  in  32 each  doodle top-left (world coords), camera top row
- blocksX, blocksY  in  NUM_BLOCKS×32 packed  block top-left, slot i at bits [32i+31:32i]
- isBlockActive  in  NUM_BLOCKS  slot enable
- pix_valid  out  1  pixel present
- pix_ready  in  1  consumer accepts
- pix_x, pix_y  out  32 each  screen coordinate of current pixel
- pix_color  out  24  pixel colour
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last pixel accepted
- collision  out  1  doodle overlapped ≥1 block pixel in last frame

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: frame_start=1 → snapshot doodleX/Y, minY, blocksX/Y, isBlockActive into internal registers; clear collision accumulator; scan counter (0,0); → SCAN. Input changes after the snapshot have no effect on the frame.
- SCAN: stage 1 evaluates the scan pixel; stage 2 is the output register (pix_*). Scan counter advances x; at SCREEN_WIDTH-1 wraps to 0 and increments y. After issuing (SCREEN_WIDTH-1, SCREEN_HEIGHT-1) → DRAIN.
- DRAIN: waits until the final pixel's handshake, then pulses frame_done and → IDLE.
- Screen mapping: sy_obj = objY − minY (32-bit, modulo 2^32). Hit tests use 33-bit arithmetic so x+width never wraps: block i hits iff active && bx ≤ x < bx+BLOCK_WIDTH && by' ≤ y < by'+BLOCK_HEIGHT; doodle analogous with DOODLE_WIDTH/HEIGHT. Objects above camera (underflowed difference) are off-screen.
- Priority: doodle > any block > background.
- collision: sticky OR of (doodle hit && any block hit) over all pixels of the frame; updated when frame_done pulses; holds until next frame_done; cleared by reset.
- frame_start while busy: ignored.
- Reset (any state, mid-frame included): next cycle IDLE, all outputs 0, snapshot discarded.

## Timing
- Reset values: pix_valid=0, pix_x=0, pix_y=0, pix_color=0, busy=0, frame_done=0, collision=0.
- frame_start sampled at edge 0 → busy=1 after edge 0; pixel (0,0) in stage 1 after edge 0; pix_valid=1 with (0,0) after edge 1.
- Handshake: transfer when pix_valid && pix_ready. While pix_valid && !pix_ready: pix_x/y/color, stage 1 and scan counter hold. pix_valid never drops without a transfer.
- Throughput with pix_ready=1: 1 pixel/cycle, no bubbles, including across row wrap.
- frame_done asserted in cycle after final transfer; busy falls same edge; pix_valid=0 then. New frame_start accepted on the frame_done cycle's edge (back-to-back frames: 2-cycle gap).

## Test plan
Use SCREEN 8×4, BLOCK 3×1, NUM_BLOCKS 2, DOODLE 2×2.
- Empty scene, ready=1: frame_start → 32 pixels (0,0)…(7,3), all BKCOLOR, first valid 2 cycles after start, frame_done 1 cycle after last, collision=0.
- Block0 at (2,5), minY=3, active: pixels (2..4,2) = BLOCK_COLOR, others BKCOLOR; same with isBlockActive=0 → all background.
- Doodle at (6,1), minY=0, block at (5,2): (6..7,1..2) DOODLE_COLOR overriding block at (6,2),(7,2); (5,2)=BLOCK_COLOR; collision=1 at frame_done.
- Random pix_ready (50%): stream matches ready=1 stream exactly, no pixel lost/duplicated, outputs stable while stalled.
- Doodle at y=1, minY=2 (underflow) and blockX=0xFFFFFFFE: no doodle/block pixels drawn.
- Reset asserted at pixel 10: next cycle all outputs 0, busy=0; fresh frame_start then produces full correct frame; frame_start during busy causes no restart.
